// File: rtl/i2cmb_env_pkg.sv
// rtl/i2cmb_env_pkg.sv - shared types and constants for the IICMB protocol checker
//
// Contents:
//   ADDR_*          Wishbone register offsets of the IICMB core
//   cmd_t           CMDR command-code encoding
//   CSR_REG         CSR bit layout  {e, ie, bb, bc, bus_id[3:0]}
//   CMDR_REG        CMDR bit layout {don, nak, al, err, r, cmd[2:0]}
//   checker_state_t command tracker states as seen on state_o
//   E0..E7          bit positions of the sticky error flags
//   status_multi()  true when more than one completion status bit is set
package i2cmb_env_pkg;

    localparam int unsigned ADDR_CSR  = 0;
    localparam int unsigned ADDR_DPR  = 1;
    localparam int unsigned ADDR_CMDR = 2;
    localparam int unsigned ADDR_FSMR = 3;

    typedef enum logic [2:0] {
        CMD_WAIT     = 3'b000,
        CMD_WRITE    = 3'b001,
        CMD_READ_ACK = 3'b010,
        CMD_READ_NAK = 3'b011,
        CMD_START    = 3'b100,
        CMD_STOP     = 3'b101,
        CMD_SET_BUS  = 3'b110,
        CMD_NO_USED  = 3'b111
    } cmd_t;

    typedef struct packed {
        logic       e;
        logic       ie;
        logic       bb;
        logic       bc;
        logic [3:0] bus_id;
    } CSR_REG;

    typedef struct packed {
        logic don;
        logic nak;
        logic al;
        logic err;
        logic r;
        cmd_t cmd;
    } CMDR_REG;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_BUSY     = 2'd2,
        ST_DONE     = 2'd3
    } checker_state_t;

    localparam int E0 = 0;  // irq while interrupts disabled
    localparam int E1 = 1;  // reserved CMDR bit read back as 1
    localparam int E2 = 2;  // unused command completed without err
    localparam int E3 = 3;  // CMDR written while a command is outstanding
    localparam int E4 = 4;  // command timeout
    localparam int E5 = 5;  // irq rising with no command outstanding
    localparam int E6 = 6;  // more than one completion status bit
    localparam int E7 = 7;  // START seen on a bus other than the selected one

    function automatic logic status_multi(input CMDR_REG c);
        return ($countones({c.don, c.nak, c.al, c.err}) > 1);
    endfunction

endpackage

// File: rtl/i2c_bus_edge_detect.sv
// rtl/i2c_bus_edge_detect.sv - START/STOP detector and busy tracker for one I2C bus
//
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous active-high reset
//   scl_i  raw I2C clock line
//   sda_i  raw I2C data line
//   start  combinational pulse: SDA fell while SCL high (synchronized domain)
//
// The two-flop synchronizers plus the SDA history flop put the START pulse
// two clocks after the pin edge, so a registered consumer sees it on the third.
module i2c_bus_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic start
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       sda_q;
    logic       stop;
    logic       busy;

    // Synchronizers reset to the idle-high bus level so release of reset
    // cannot fabricate an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            sda_q    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            sda_q    <= sda_sync[1];
            if (start) begin
                busy <= 1'b1;
            end else if (stop && busy) begin
                busy <= 1'b0;
            end
        end
    end

    assign start = scl_sync[1] &  sda_q & ~sda_sync[1];
    assign stop  = scl_sync[1] & ~sda_q &  sda_sync[1];

endmodule

// File: rtl/i2cmb_protocol_checker.sv
// rtl/i2cmb_protocol_checker.sv - passive IICMB protocol checker with sticky error flags
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cyc_o stb_o ack_i we_o  tapped Wishbone handshake of the core's master port
//   adr_o dat_o dat_i       tapped Wishbone address, write data, read data
//   irq_i                   core interrupt
//   scl_i, sda_i            one bit per monitored I2C bus
//   clr_i                   synchronous clear of err_flags_o (new causes still win)
//   err_flags_o             sticky per-cause error flags E0..E7
//   err_valid_o             one-cycle pulse when any flag goes from 0 to 1
//   err_bus_o               bus index of the most recent foreign START (E7)
//   cmd_count_o             completed-command counter, wraps
//   state_o                 tracker state: 0 DISABLED, 1 IDLE, 2 BUSY, 3 DONE
module i2cmb_protocol_checker #(
    parameter int          NUM_I2C_BUSSES     = 1,
    parameter int          WB_ADDR_WIDTH      = 2,
    parameter int          WB_DATA_WIDTH      = 8,
    parameter int          CMD_TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  CHECK_EN           = 8'hFF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cyc_o,
    input  logic                      stb_o,
    input  logic                      ack_i,
    input  logic [WB_ADDR_WIDTH-1:0]  adr_o,
    input  logic                      we_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      irq_i,
    input  logic [NUM_I2C_BUSSES-1:0] scl_i,
    input  logic [NUM_I2C_BUSSES-1:0] sda_i,
    input  logic                      clr_i,
    output logic [7:0]                err_flags_o,
    output logic                      err_valid_o,
    output logic [3:0]                err_bus_o,
    output logic [15:0]               cmd_count_o,
    output logic [1:0]                state_o
);

    import i2cmb_env_pkg::*;

    localparam logic [1:0] S_DISABLED = ST_DISABLED;
    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_BUSY     = ST_BUSY;
    localparam logic [1:0] S_DONE     = ST_DONE;

    localparam int             TW   = (CMD_TIMEOUT_CYCLES > 1) ? $clog2(CMD_TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0]  TMAX = TW'(CMD_TIMEOUT_CYCLES);

    // Bus handshakes and decoded register accesses
    logic wr_hs, rd_hs;
    logic csr_wr, dpr_wr, cmdr_wr, cmdr_rd;

    assign wr_hs   = cyc_o & stb_o &  we_o & ack_i;
    assign rd_hs   = cyc_o & stb_o & ~we_o & ack_i;
    assign csr_wr  = wr_hs && (adr_o == WB_ADDR_WIDTH'(ADDR_CSR));
    assign dpr_wr  = wr_hs && (adr_o == WB_ADDR_WIDTH'(ADDR_DPR));
    assign cmdr_wr = wr_hs && (adr_o == WB_ADDR_WIDTH'(ADDR_CMDR));
    assign cmdr_rd = rd_hs && (adr_o == WB_ADDR_WIDTH'(ADDR_CMDR));

    CSR_REG  wcsr;
    CMDR_REG wcmd;
    CMDR_REG rstat;

    assign wcsr  = CSR_REG'(dat_o[7:0]);
    assign wcmd  = CMDR_REG'(dat_o[7:0]);
    assign rstat = CMDR_REG'(dat_i[7:0]);

    // Shadow registers and tracker state
    logic [1:0]    state, state_nxt;
    logic          csr_ie;
    logic [3:0]    dpr_q;
    logic [3:0]    bus_id;
    cmd_t          cmd_q;
    logic          irq_q;
    logic [TW-1:0] to_cnt;
    logic          to_fired;

    logic       irq_rise;
    logic       status_any;
    logic       completion;
    logic       rd_complete;
    logic [7:0] cause;
    logic [7:0] en_cause;

    // I2C busses
    logic [NUM_I2C_BUSSES-1:0] start_v;
    logic                      foreign_start;
    logic [3:0]                foreign_idx;

    for (genvar b = 0; b < NUM_I2C_BUSSES; b++) begin : g_bus
        i2c_bus_edge_detect u_det (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .scl_i (scl_i[b]),
            .sda_i (sda_i[b]),
            .start (start_v[b])
        );
    end

    // Lowest-numbered offending bus is reported when several start together.
    always_comb begin
        foreign_start = 1'b0;
        foreign_idx   = 4'd0;
        for (int b = NUM_I2C_BUSSES - 1; b >= 0; b--) begin
            if (start_v[b] && (4'(b) != bus_id)) begin
                foreign_start = 1'b1;
                foreign_idx   = 4'(b);
            end
        end
    end

    assign irq_rise   = irq_i & ~irq_q;
    assign status_any = rstat.don | rstat.nak | rstat.al | rstat.err;

    // With interrupts off, software polls CMDR and the read that shows status
    // is itself the completion; with interrupts on, the irq edge completes and
    // the following read in DONE carries the status.
    assign completion  = (csr_ie && irq_rise) || (!csr_ie && cmdr_rd && status_any);
    assign rd_complete = cmdr_rd && ((state == S_DONE) ||
                                     (state == S_BUSY && !csr_ie && status_any));

    always_comb begin
        cause     = 8'h00;
        cause[E0] = irq_i && !csr_ie;
        cause[E1] = cmdr_rd && rstat.r;
        cause[E2] = rd_complete && (cmd_q == CMD_NO_USED) && !rstat.err;
        cause[E3] = cmdr_wr && (state == S_BUSY);
        cause[E4] = (state == S_BUSY) && (to_cnt == TMAX) && !to_fired;
        cause[E5] = irq_rise && ((state == S_IDLE) || (state == S_DISABLED));
        cause[E6] = rd_complete && status_multi(rstat);
        cause[E7] = foreign_start;
    end

    assign en_cause = cause & CHECK_EN;

    always_comb begin
        state_nxt = state;
        if (csr_wr && !wcsr.e) begin
            state_nxt = S_DISABLED;
        end else begin
            case (state)
                S_DISABLED: if (csr_wr && wcsr.e) state_nxt = S_IDLE;
                S_IDLE:     if (cmdr_wr)          state_nxt = S_BUSY;
                S_BUSY:     if (completion)       state_nxt = S_DONE;
                S_DONE:     if (cmdr_rd)          state_nxt = S_IDLE;
                default:                          state_nxt = S_DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_DISABLED;
            csr_ie      <= 1'b0;
            dpr_q       <= 4'd0;
            bus_id      <= 4'd0;
            cmd_q       <= CMD_WAIT;
            irq_q       <= 1'b0;
            to_cnt      <= '0;
            to_fired    <= 1'b0;
            err_flags_o <= 8'h00;
            err_valid_o <= 1'b0;
            err_bus_o   <= 4'd0;
            cmd_count_o <= 16'd0;
        end else begin
            state <= state_nxt;
            irq_q <= irq_i;

            if (csr_wr) begin
                csr_ie <= wcsr.ie;
            end
            if (dpr_wr) begin
                dpr_q <= dat_o[3:0];
            end
            if (cmdr_wr && (wcmd.cmd == CMD_SET_BUS)) begin
                bus_id <= dpr_q;
            end

            // Timeout counter saturates at the limit; to_fired keeps E4 to one
            // cause per command even while the counter sits there.
            if (state == S_IDLE && state_nxt == S_BUSY) begin
                cmd_q    <= wcmd.cmd;
                to_cnt   <= '0;
                to_fired <= 1'b0;
            end else if (state == S_BUSY) begin
                if (to_cnt != TMAX) begin
                    to_cnt <= to_cnt + 1'b1;
                end
                if (cause[E4]) begin
                    to_fired <= 1'b1;
                end
            end

            if (state == S_DONE && state_nxt == S_IDLE) begin
                cmd_count_o <= cmd_count_o + 16'd1;
            end

            // A cause in the same cycle as clr_i survives the clear.
            err_flags_o <= clr_i ? en_cause : (err_flags_o | en_cause);
            err_valid_o <= |(en_cause & ~err_flags_o);
            if (en_cause[E7]) begin
                err_bus_o <= foreign_idx;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_i2cmb_protocol_checker.sv
// tb/tb_i2cmb_protocol_checker.sv - self-checking bench for i2cmb_protocol_checker
module tb_i2cmb_protocol_checker;

    localparam int N = 4;
    localparam int T = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cyc = 1'b0, stb = 1'b0, ack = 1'b0, we = 1'b0;
    logic [1:0]   adr = 2'd0;
    logic [7:0]   wdat = 8'h00, rdat = 8'h00;
    logic         irq = 1'b0, clr = 1'b0;
    logic [N-1:0] scl = '1, sda = '1;
    logic [7:0]   err_flags;
    logic         err_valid;
    logic [3:0]   err_bus;
    logic [15:0]  cmd_count;
    logic [1:0]   state;

    i2cmb_protocol_checker #(
        .NUM_I2C_BUSSES     (N),
        .WB_ADDR_WIDTH      (2),
        .WB_DATA_WIDTH      (8),
        .CMD_TIMEOUT_CYCLES (T),
        .CHECK_EN           (8'hFF)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cyc_o       (cyc),
        .stb_o       (stb),
        .ack_i       (ack),
        .adr_o       (adr),
        .we_o        (we),
        .dat_o       (wdat),
        .dat_i       (rdat),
        .irq_i       (irq),
        .scl_i       (scl),
        .sda_i       (sda),
        .clr_i       (clr),
        .err_flags_o (err_flags),
        .err_valid_o (err_valid),
        .err_bus_o   (err_bus),
        .cmd_count_o (cmd_count),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // op: 0 idle, 1 write, 2 read. One bus cycle, then outputs are sampled 1ns after the edge.
    task automatic drive(input int op, input int a, input int d, input bit irq_v, input bit clr_v);
        cyc  = (op != 0);
        stb  = (op != 0);
        ack  = (op != 0);
        we   = (op == 1);
        adr  = 2'(a);
        wdat = (op == 1) ? 8'(d) : 8'h00;
        rdat = (op == 2) ? 8'(d) : 8'h00;
        irq  = irq_v;
        clr  = clr_v;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; ack = 1'b0; we = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        cyc = 1'b0; stb = 1'b0; ack = 1'b0; we = 1'b0;
        irq = 1'b0; clr = 1'b0; scl = '1; sda = '1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Reference model: spec rules applied once per clock edge.
    int       m_state, m_cmd, m_busy, m_count;
    bit       m_ie, m_valid, m_irq_prev, m_fired;
    bit [7:0] m_flags;

    task automatic model_reset();
        m_state = 0; m_cmd = 0; m_busy = 0; m_count = 0;
        m_ie = 0; m_valid = 0; m_irq_prev = 0; m_fired = 0; m_flags = 0;
    endtask

    task automatic model_edge(input int op, input int a, input bit [7:0] d, input bit irq_v, input bit clr_v);
        bit       wr, rd, rise, done_rd;
        bit [3:0] st;
        bit [7:0] c;
        int       nxt;
        wr      = (op == 1);
        rd      = (op == 2);
        st      = d[7:4];
        rise    = irq_v && !m_irq_prev;
        done_rd = rd && a == 2 && (m_state == 3 || (m_state == 2 && !m_ie && st != 0));
        c       = 8'h00;
        c[0]    = irq_v && !m_ie;
        c[1]    = rd && a == 2 && d[3];
        c[2]    = done_rd && m_cmd == 7 && !d[4];
        c[3]    = wr && a == 2 && m_state == 2;
        c[4]    = m_state == 2 && m_busy >= T && !m_fired;
        c[5]    = rise && m_state < 2;
        c[6]    = done_rd && $countones(st) > 1;
        m_valid = (c & ~m_flags) != 0;
        m_flags = clr_v ? c : (m_flags | c);
        if (c[4]) m_fired = 1;
        nxt = m_state;
        if (wr && a == 0 && !d[7]) nxt = 0;
        else if (m_state == 0 && wr && a == 0) nxt = 1;
        else if (m_state == 1 && wr && a == 2) nxt = 2;
        else if (m_state == 2 && ((m_ie && rise) || (!m_ie && rd && a == 2 && st != 0))) nxt = 3;
        else if (m_state == 3 && rd && a == 2) nxt = 1;
        if (m_state == 1 && nxt == 2) begin
            m_busy = 0; m_fired = 0; m_cmd = int'(d[2:0]);
        end else if (m_state == 2 && m_busy < T) begin
            m_busy++;
        end
        if (m_state == 3 && nxt == 1) m_count = (m_count + 1) % 65536;
        if (wr && a == 0) m_ie = d[6];
        m_state    = nxt;
        m_irq_prev = irq_v;
    endtask

    typedef struct {
        int         op;
        int         adr;
        int         dat;
        bit         irq;
        bit         clr;
        logic [1:0] st;
        logic [7:0] fl;
        logic       vl;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int op, input int a, input int d, input bit i, input bit c,
                       input int st, input int fl, input int vl, input int cnt);
        vec_t v;
        v.op = op; v.adr = a; v.dat = d; v.irq = i; v.clr = c;
        v.st = 2'(st); v.fl = 8'(fl); v.vl = 1'(vl); v.cnt = 16'(cnt);
        vecs.push_back(v);
    endtask

    initial begin
        int first, pulses, lat;
        int op, a, d, r;
        bit irq_v, clr_v;
        bit [7:0] rd_pick [8];

        // Directed vectors: {op, adr, data, irq, clr} -> {state, flags, valid, count}
        add(1, 0, 'hC0, 0, 0,  1, 'h00, 0, 0);
        add(1, 2, 'h04, 0, 0,  2, 'h00, 0, 0);
        add(0, 0, 0,    1, 0,  3, 'h00, 0, 0);
        add(0, 0, 0,    0, 0,  3, 'h00, 0, 0);
        add(2, 2, 'h80, 0, 0,  1, 'h00, 0, 1);
        add(1, 2, 'h01, 0, 0,  2, 'h00, 0, 1);
        add(0, 0, 0,    1, 0,  3, 'h00, 0, 1);
        add(0, 0, 0,    0, 0,  3, 'h00, 0, 1);
        add(2, 2, 'hC8, 0, 0,  1, 'h42, 1, 2);
        add(0, 0, 0,    0, 1,  1, 'h00, 0, 2);
        add(1, 2, 'h07, 0, 0,  2, 'h00, 0, 2);
        add(0, 0, 0,    1, 0,  3, 'h00, 0, 2);
        add(0, 0, 0,    0, 0,  3, 'h00, 0, 2);
        add(2, 2, 'h80, 0, 0,  1, 'h04, 1, 3);
        add(2, 2, 'h10, 0, 0,  1, 'h04, 0, 3);
        add(0, 0, 0,    1, 0,  1, 'h24, 1, 3);
        add(0, 0, 0,    0, 0,  1, 'h24, 0, 3);
        add(1, 0, 'h00, 0, 0,  0, 'h24, 0, 3);
        add(0, 0, 0,    1, 0,  0, 'h25, 1, 3);
        add(0, 0, 0,    0, 1,  0, 'h00, 0, 3);
        add(0, 0, 0,    1, 1,  0, 'h21, 1, 3);
        add(0, 0, 0,    0, 1,  0, 'h00, 0, 3);
        add(1, 0, 'h80, 0, 0,  1, 'h00, 0, 3);
        add(1, 2, 'h07, 0, 0,  2, 'h00, 0, 3);
        add(2, 2, 'h10, 0, 0,  3, 'h00, 0, 3);
        add(2, 2, 'h10, 0, 0,  1, 'h00, 0, 4);

        // Reset values while rst is held
        @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_flags", err_flags, 0);
        check("rst_valid", err_valid, 0);
        check("rst_bus", err_bus, 0);
        check("rst_count", cmd_count, 0);

        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].adr, vecs[i].dat, vecs[i].irq, vecs[i].clr);
            check($sformatf("vec%0d_state", i), state, vecs[i].st);
            check($sformatf("vec%0d_flags", i), err_flags, vecs[i].fl);
            check($sformatf("vec%0d_valid", i), err_valid, vecs[i].vl);
            check($sformatf("vec%0d_count", i), cmd_count, vecs[i].cnt);
        end

        // E0: irq raised the cycle after CSR=80 -> flag two cycles after the write
        do_reset();
        drive(1, 0, 'h80, 0, 0);
        check("e0_before", err_flags, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0);
            if (i == 0) check("e0_flag_at_2", err_flags[0], 1);
            if (err_valid) pulses++;
        end
        check("e0_pulses", pulses, 1);
        check("e0_flags", err_flags, 'h21);

        // E3: second CMDR write while BUSY
        do_reset();
        drive(1, 0, 'h80, 0, 0);
        drive(1, 2, 'h01, 0, 0);
        drive(1, 2, 'h02, 0, 0);
        check("e3_flags", err_flags, 'h08);
        check("e3_valid", err_valid, 1);
        check("e3_state", state, 2);

        // E4: timeout edge and single pulse
        do_reset();
        drive(1, 0, 'h80, 0, 0);
        drive(1, 2, 'h04, 0, 0);
        first = 0; pulses = 0;
        for (int i = 1; i <= 150; i++) begin
            drive(0, 0, 0, 0, 0);
            if (err_flags[4] && first == 0) first = i;
            if (err_valid) pulses++;
        end
        check("e4_cycle", first, T + 1);
        check("e4_pulses", pulses, 1);
        check("e4_flags", err_flags, 'h10);

        // E7: bus_id=2, START on bus 2 is legal, START on bus 1 is not
        do_reset();
        drive(1, 0, 'h80, 0, 0);
        drive(1, 1, 'h02, 0, 0);
        drive(1, 2, 'h06, 0, 0);
        sda[2] = 1'b0;
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
        check("e7_own_bus", err_flags, 0);
        sda[2] = 1'b1;
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
        sda[1] = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            drive(0, 0, 0, 0, 0);
            if (err_flags[7] && lat == 0) lat = i;
        end
        check("e7_within_3", (lat >= 1 && lat <= 3), 1);
        check("e7_bus", err_bus, 1);
        check("e7_flags", err_flags, 'h80);
        sda[1] = 1'b1;

        // Asynchronous reset in the middle of a command
        do_reset();
        drive(1, 0, 'hC0, 0, 0);
        drive(1, 2, 'h04, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(2, 2, 'h80, 0, 0);
        drive(1, 2, 'h04, 0, 0);
        drive(1, 2, 'h02, 0, 0);
        check("mid_pre_state", state, 2);
        check("mid_pre_count", cmd_count, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_async_state", state, 0);
        check("mid_async_flags", err_flags, 0);
        check("mid_async_count", cmd_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        irq = 1'b0;
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        check("mid_after_flags", err_flags, 0);
        check("mid_after_valid", err_valid, 0);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        rd_pick = '{8'h80, 8'h40, 8'h20, 8'h10, 8'hC0, 8'h90, 8'h00, 8'h08};
        irq_v = 0;
        for (int cyc_n = 0; cyc_n < 1500; cyc_n++) begin
            r = $urandom_range(0, 99);
            op = (r < 40) ? 0 : (r < 70) ? 1 : 2;
            a = ($urandom_range(0, 1) == 0) ? 2 : $urandom_range(0, 3);
            d = $urandom_range(0, 255);
            if (op == 1 && a == 0) d = {($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 6'h00};
            else if (op == 1 && a == 2) d = $urandom_range(0, 7);
            else if (op == 2 && a == 2 && $urandom_range(0, 3) != 0) d = rd_pick[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) irq_v = ~irq_v;
            clr_v = ($urandom_range(0, 19) == 0);
            drive(op, a, d, irq_v, clr_v);
            model_edge(op, a, 8'(d), irq_v, clr_v);
            check($sformatf("rnd%0d_state", cyc_n), state, m_state);
            check($sformatf("rnd%0d_flags", cyc_n), err_flags, m_flags);
            check($sformatf("rnd%0d_valid", cyc_n), err_valid, m_valid);
            check($sformatf("rnd%0d_count", cyc_n), cmd_count, m_count);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
